led_tuner_sched: RTL and testbench

Controller and scheduler for the three-chip TLC5916 tuner LED serializer. It generates the serializer bit-rate enable and holds the latest LED pattern and current-gain configuration from the host. It arbitrates host pattern updates, configuration updates and periodic refresh into single serializer write transactions. It sits between the host register interface and the serializer's parallel port.

---
 rtl/led_tuner_sched.sv | 184 ++++++++++++++++++
 tb/tb_led_tuner_sched.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_tuner_sched.sv
// Write scheduler for the three-chip TLC5916 tuner LED serializer: holds host pattern/config,
// arbitrates config, pattern and periodic refresh into serializer write transactions.
module led_tuner_sched #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned CLK_DIV  = 16,
  parameter int unsigned REFRESH  = 1048576,
  parameter logic [7:0]  CFG_INIT = 8'hFF,
  parameter int unsigned WD_MAX   = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] pat_i,
  input  logic              pat_wr_i,
  input  logic [7:0]        cfg_i,
  input  logic              cfg_wr_i,
  output logic              wr_o,
  output logic              mode_o,
  output logic [DATA_W-1:0] data_o,
  output logic              en_o,
  input  logic              busy_i,
  output logic              busy_o,
  output logic              err_o
);

  localparam int unsigned NCHIP    = DATA_W / 8;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned REF_W    = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam int unsigned WD_W     = (WD_MAX > 1) ? $clog2(WD_MAX) : 1;
  localparam int unsigned REF_LAST = (REFRESH > 0) ? REFRESH - 1 : 0;
  localparam int unsigned WD_LAST  = (WD_MAX > 0) ? WD_MAX - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG_WR,
    S_DAT_WR,
    S_ACK,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   pat_q, pat_d;
  logic [7:0]          cfg_q, cfg_d;
  logic                cfg_pend_q, cfg_pend_d;
  logic                pat_pend_q, pat_pend_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [REF_W-1:0]    ref_q, ref_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                wr_q, wr_d;
  logic                mode_q, mode_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                en_q, en_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    cfg_d      = cfg_q;
    cfg_pend_d = cfg_pend_q;
    pat_pend_d = pat_pend_q;
    ref_d      = '0;
    wd_d       = wd_q;
    wr_d       = wr_q;
    mode_d     = mode_q;
    data_d     = data_q;
    err_d      = err_q;

    div_d = (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_q + DIV_W'(1);
    en_d  = (div_q == DIV_W'(CLK_DIV - 1));

    case (state_q)
      S_IDLE: begin
        if (REFRESH != 0) begin
          if (ref_q == REF_W'(REF_LAST)) begin
            ref_d      = '0;
            pat_pend_d = 1'b1;
          end else begin
            ref_d = ref_q + REF_W'(1);
          end
        end
        if (cfg_pend_q) begin
          state_d = S_CFG_WR;
        end else if (pat_pend_q) begin
          state_d = S_DAT_WR;
        end
      end
      S_CFG_WR: begin
        data_d     = {NCHIP{cfg_q}};
        mode_d     = 1'b1;
        wr_d       = 1'b1;
        wd_d       = '0;
        cfg_pend_d = 1'b0;
        pat_pend_d = 1'b1;
        state_d    = S_ACK;
      end
      S_DAT_WR: begin
        data_d     = pat_q;
        mode_d     = 1'b0;
        wr_d       = 1'b1;
        wd_d       = '0;
        pat_pend_d = 1'b0;
        state_d    = S_ACK;
      end
      S_ACK: begin
        if (busy_i) begin
          wr_d    = 1'b0;
          state_d = S_DONE;
        end else if (wd_q == WD_W'(WD_LAST)) begin
          // mode_q identifies which request was in flight, so its pend flag is restored
          wr_d  = 1'b0;
          err_d = 1'b1;
          if (mode_q) begin
            cfg_pend_d = 1'b1;
          end else begin
            pat_pend_d = 1'b1;
          end
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_DONE: begin
        if (!busy_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Host strobes take precedence over the in-flight clear, so a mid-transaction write re-sends
    if (pat_wr_i) begin
      pat_d      = pat_i;
      pat_pend_d = 1'b1;
    end
    if (cfg_wr_i) begin
      cfg_d      = cfg_i;
      cfg_pend_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE) | cfg_pend_d | pat_pend_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      pat_q      <= '0;
      cfg_q      <= CFG_INIT;
      cfg_pend_q <= 1'b1;
      pat_pend_q <= 1'b0;
      div_q      <= '0;
      ref_q      <= '0;
      wd_q       <= '0;
      wr_q       <= 1'b0;
      mode_q     <= 1'b0;
      data_q     <= '0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      cfg_q      <= cfg_d;
      cfg_pend_q <= cfg_pend_d;
      pat_pend_q <= pat_pend_d;
      div_q      <= div_d;
      ref_q      <= ref_d;
      wd_q       <= wd_d;
      wr_q       <= wr_d;
      mode_q     <= mode_d;
      data_q     <= data_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign wr_o   = wr_q;
  assign mode_o = mode_q;
  assign data_o = data_q;
  assign en_o   = en_q;
  assign busy_o = busy_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_led_tuner_sched.sv
// Randomized self-checking bench for led_tuner_sched against a transaction-level model
// and a simple echoing serializer.
module tb_led_tuner_sched;

  localparam int DW  = 24;
  localparam int CD  = 16;
  localparam int RF  = 100;
  localparam int WDM = 8;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic [DW-1:0] pat_i;
  logic          pat_wr_i;
  logic [7:0]    cfg_i;
  logic          cfg_wr_i;
  logic          wr_o;
  logic          mode_o;
  logic [DW-1:0] data_o;
  logic          en_o;
  logic          busy_i;
  logic          busy_o;
  logic          err_o;

  led_tuner_sched #(
    .DATA_W  (DW),
    .CLK_DIV (CD),
    .REFRESH (RF),
    .CFG_INIT(8'hFF),
    .WD_MAX  (WDM)
  ) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .pat_i   (pat_i),
    .pat_wr_i(pat_wr_i),
    .cfg_i   (cfg_i),
    .cfg_wr_i(cfg_wr_i),
    .wr_o    (wr_o),
    .mode_o  (mode_o),
    .data_o  (data_o),
    .en_o    (en_o),
    .busy_i  (busy_i),
    .busy_o  (busy_o),
    .err_o   (err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef logic [DW:0] txn_t;  // {mode, data}
  txn_t obs_q[$];
  txn_t exp_q[$];
  logic [DW-1:0] mdl_pat;
  logic [7:0]    mdl_cfg;

  // Serializer stand-in: raise busy ser_lat clocks after wr_o, hold it ser_hold more clocks
  bit ser_en   = 1'b1;
  int ser_lat  = 1;
  int ser_hold = 1;
  initial begin
    int lat_cnt;
    int hold_cnt;
    lat_cnt  = 0;
    hold_cnt = 0;
    busy_i   = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      if (!ser_en) begin
        busy_i  = 1'b0;
        lat_cnt = 0;
      end else if (busy_i) begin
        if (hold_cnt == 0) busy_i = 1'b0;
        else hold_cnt--;
      end else if (wr_o) begin
        if (lat_cnt >= ser_lat) begin
          busy_i   = 1'b1;
          hold_cnt = ser_hold;
          lat_cnt  = 0;
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  // Record each write request and require mode/data stable while it is held
  initial begin
    logic prev;
    txn_t last;
    prev = 1'b0;
    last = '0;
    forever begin
      @(negedge clk_i);
      if (rst_n_i === 1'b1 && wr_o === 1'b1) begin
        if (!prev) begin
          last = {mode_o, data_o};
          obs_q.push_back(last);
        end else begin
          check("wr_stable", 32'({mode_o, data_o}), 32'(last));
        end
      end
      prev = (rst_n_i === 1'b1) && (wr_o === 1'b1);
    end
  end

  // en_o: first pulse CD clocks after reset release, then every CD clocks
  initial begin
    int  n;
    bit  first;
    @(posedge rst_n_i);
    n     = 0;
    first = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      n++;
      if (en_o) begin
        check(first ? "en_first" : "en_period", n, CD);
        first = 1'b0;
        n     = 0;
      end else if (n > CD) begin
        check("en_missing", n, CD);
        n = 0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (busy_o !== 1'b0 && n < 2000);
    if (busy_o !== 1'b0) check(tag, 32'(busy_o), 32'd0);
  endtask

  // One-clock host strobe plus the model's expected transaction sequence
  task automatic strobe(input bit dp, input bit dc, input logic [DW-1:0] p, input logic [7:0] c);
    pat_i    = p;
    cfg_i    = c;
    pat_wr_i = dp;
    cfg_wr_i = dc;
    @(negedge clk_i);
    pat_wr_i = 1'b0;
    cfg_wr_i = 1'b0;
    if (dp) mdl_pat = p;
    if (dc) mdl_cfg = c;
    if (dc) begin
      exp_q.push_back({1'b1, {(DW/8){mdl_cfg}}});
      exp_q.push_back({1'b0, mdl_pat});
    end else if (dp) begin
      exp_q.push_back({1'b0, mdl_pat});
    end
  endtask

  task automatic compare_txns(input string tag);
    int n;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check(tag, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int  n;
    bit  dropped;
    int  kind;
    rst_n_i  = 1'b0;
    pat_i    = '0;
    pat_wr_i = 1'b0;
    cfg_i    = '0;
    cfg_wr_i = 1'b0;
    mdl_pat  = '0;
    mdl_cfg  = 8'hFF;

    repeat (3) @(negedge clk_i);
    check("rst_wr", 32'(wr_o), 0);
    check("rst_mode", 32'(mode_o), 0);
    check("rst_data", 32'(data_o), 0);
    check("rst_en", 32'(en_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_err", 32'(err_o), 0);

    // Reset leaves config pending: config write then the (zero) pattern
    rst_n_i = 1'b1;
    exp_q.push_back({1'b1, 24'hFFFFFF});
    exp_q.push_back({1'b0, 24'h000000});
    repeat (2) @(negedge clk_i);
    check("boot_busy", 32'(busy_o), 1);
    wait_idle("boot_idle_timeout");
    compare_txns("boot_seq");
    check("boot_err", 32'(err_o), 0);

    // Latency from strobe to wr_o, and hold until busy_i
    ser_lat = 3;
    strobe(1'b1, 1'b0, 24'h00A5C3, 8'h00);
    check("lat_e0", 32'(wr_o), 0);
    @(negedge clk_i);
    check("lat_e1", 32'(wr_o), 0);
    @(negedge clk_i);
    check("lat_e2", 32'(wr_o), 1);
    check("lat_mode", 32'(mode_o), 0);
    check("lat_data", 32'(data_o), 32'h00A5C3);
    dropped = 1'b0;
    for (int i = 0; i < 20 && !dropped; i++) begin
      if (busy_i) begin
        @(negedge clk_i);
        check("wr_drop", 32'(wr_o), 0);
        dropped = 1'b1;
      end else begin
        @(negedge clk_i);
        check("wr_hold", 32'(wr_o), 1);
      end
    end
    if (!dropped) check("wr_drop_timeout", 0, 1);
    wait_idle("lat_idle_timeout");
    compare_txns("lat_seq");

    // Same-clock pattern and config
    ser_lat = 1;
    strobe(1'b1, 1'b1, 24'h123456, 8'h40);
    wait_idle("both_idle_timeout");
    compare_txns("both_seq");

    // Two pattern writes during DONE collapse into one re-send of the last
    ser_hold = 5;
    strobe(1'b1, 1'b0, 24'h000777, 8'h00);
    n = 0;
    while (!(busy_i === 1'b1 && wr_o === 1'b0) && n < 30) begin
      @(negedge clk_i);
      n++;
    end
    check("done_reached", 32'(busy_i === 1'b1 && wr_o === 1'b0), 1);
    pat_i    = 24'h000001;
    pat_wr_i = 1'b1;
    @(negedge clk_i);
    pat_i = 24'h000002;
    @(negedge clk_i);
    pat_wr_i = 1'b0;
    mdl_pat  = 24'h000002;
    exp_q.push_back({1'b0, 24'h000002});
    wait_idle("done_idle_timeout");
    compare_txns("done_seq");

    // Watchdog: no busy_i response
    ser_en   = 1'b0;
    ser_hold = 1;
    strobe(1'b1, 1'b0, 24'hBEEF00, 8'h00);
    @(negedge clk_i);
    @(negedge clk_i);
    n = 0;
    while (wr_o === 1'b1 && n < 20) begin
      n++;
      @(negedge clk_i);
    end
    check("wd_len", n, WDM);
    check("wd_err", 32'(err_o), 1);
    n = 0;
    while (wr_o !== 1'b1 && n < 10) begin
      check("wd_busy", 32'(busy_o), 1);
      @(negedge clk_i);
      n++;
    end
    check("wd_retry_gap", n, 2);
    ser_lat = 0;
    ser_en  = 1'b1;
    exp_q.push_back({1'b0, 24'hBEEF00});
    wait_idle("wd_idle_timeout");
    compare_txns("wd_seq");
    check("wd_err_sticky", 32'(err_o), 1);

    // Randomized single-clock strobes with random serializer timing
    for (int it = 0; it < 25; it++) begin
      ser_lat  = $urandom_range(0, 5);
      ser_hold = $urandom_range(0, 4);
      kind     = $urandom_range(1, 3);
      strobe(kind[0], kind[1], DW'($urandom), 8'($urandom));
      wait_idle("rnd_idle_timeout");
      compare_txns("rnd_seq");
    end

    // Automatic refresh after REFRESH idle clocks
    ser_lat  = 1;
    ser_hold = 1;
    strobe(1'b1, 1'b0, 24'h0F0F0F, 8'h00);
    for (int r = 0; r < 2; r++) begin
      wait_idle("ref_idle_timeout");
      compare_txns("ref_seq");
      n = 0;
      while (busy_o === 1'b0 && n < 400) begin
        n++;
        @(negedge clk_i);
      end
      check("refresh_idle", n, RF);
      exp_q.push_back({1'b0, 24'h0F0F0F});
    end
    wait_idle("ref_last_timeout");
    compare_txns("ref_last");
    check("err_final", 32'(err_o), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
